// File: rtl/snn_pkg.sv
// Shared stream field positions and decoder FSM encodings for the SNN spike pipeline.
package snn_pkg;

  localparam int ID_MSB = 31;
  localparam int ID_LSB = 16;
  localparam int TS_MSB = 47;
  localparam int TS_LSB = 32;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_ARGMAX = 2'd1,
    ST_RESULT = 2'd2
  } dec_state_t;

endpackage

// File: rtl/snn_spike_count_decoder.sv
// Counts spikes per output neuron over a tlast-delimited window, then scans for the argmax.
// Result valid NUM_CLASSES+1 cycles after the tlast beat; tready held low from tlast until the result is taken.
module snn_spike_count_decoder
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH  = 48,
  parameter int NUM_CLASSES = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [7:0]             result_class,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [31:0]            window_spikes,
  output logic [31:0]            dropped_spikes,
  output logic                   busy
);

  // One extra code beyond the last class marks "scan finished".
  localparam int SCAN_W = $clog2(NUM_CLASSES + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  dec_state_t state, state_next;

  logic [COUNT_WIDTH-1:0] counters [NUM_CLASSES];
  logic [SCAN_W-1:0]      scan_idx;
  logic [COUNT_WIDTH-1:0] best;
  logic [7:0]             best_idx;
  logic [COUNT_WIDTH-1:0] scan_val;

  logic [15:0] neuron_id;
  logic        id_in_range;
  logic        beat;
  logic        res_take;
  logic        scan_done;
  logic        unused_fields;

  assign neuron_id     = s_axis_tdata[ID_MSB:ID_LSB];
  assign unused_fields = ^{s_axis_tdata[TS_MSB:TS_LSB], s_axis_tdata[ID_LSB-1:0]};
  assign id_in_range   = neuron_id < 16'(NUM_CLASSES);
  assign beat          = (state == ST_ACCUM) && enable && s_axis_tvalid;
  assign res_take      = (state == ST_RESULT) && enable && result_ready;
  assign scan_done     = scan_idx == SCAN_W'(NUM_CLASSES);

  always_comb begin
    scan_val = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx == SCAN_W'(i)) scan_val = counters[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    result_valid  = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_ACCUM: begin
        s_axis_tready = enable;
        busy          = 1'b0;
        if (beat && s_axis_tlast) state_next = ST_ARGMAX;
      end
      ST_ARGMAX: begin
        if (enable && scan_done) state_next = ST_RESULT;
      end
      ST_RESULT: begin
        result_valid = 1'b1;
        if (res_take) state_next = ST_ACCUM;
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) counters[i] <= '0;
      window_spikes  <= '0;
      dropped_spikes <= '0;
      result_class   <= '0;
      result_count   <= '0;
      scan_idx       <= '0;
      best           <= '0;
      best_idx       <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (res_take)
          counters[i] <= '0;
        else if (beat && id_in_range && neuron_id == 16'(i) && counters[i] != CNT_MAX)
          counters[i] <= counters[i] + 1'b1;
      end

      if (beat) begin
        window_spikes <= window_spikes + 32'd1;
        if (!id_in_range) dropped_spikes <= dropped_spikes + 32'd1;
        if (s_axis_tlast) begin
          scan_idx <= '0;
          best     <= '0;
          best_idx <= '0;
        end
      end

      // Strict compare keeps the lowest index on ties.
      if (state == ST_ARGMAX && enable) begin
        if (!scan_done) begin
          if (scan_val > best) begin
            best     <= scan_val;
            best_idx <= 8'(scan_idx);
          end
          scan_idx <= scan_idx + 1'b1;
        end else begin
          result_class <= best_idx;
          result_count <= best;
        end
      end

      if (res_take) window_spikes <= '0;
    end
  end

endmodule

// File: tb/tb_snn_spike_count_decoder.sv
// Scoreboard bench: driver pushes window predictions, monitor pops them when a result appears.
module tb_snn_spike_count_decoder;

  localparam int DW   = 48;
  localparam int NC   = 10;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [7:0]    result_class;
  logic [CW-1:0] result_count;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [31:0]   window_spikes;
  logic [31:0]   dropped_spikes;
  logic          busy;

  snn_spike_count_decoder #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .result_class(result_class), .result_count(result_count),
    .result_valid(result_valid), .result_ready(result_ready),
    .window_spikes(window_spikes), .dropped_spikes(dropped_spikes), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cls;
    int cnt;
    int win;
    int drop;
    int tlast_cyc;
    int hold;
  } exp_t;

  exp_t exp_q[$];
  int   win_ids[$];
  int   checks = 0;
  int   failures = 0;
  int   model_dropped = 0;
  bit   mon_busy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives win_ids as one window; the model counts ids and picks the first class holding the max.
  task automatic send_window(input bit push, input int hold);
    int counts[NC];
    int win;
    int tl;
    int maxv;
    int cls;
    exp_t e;
    win = 0;
    tl = 0;
    foreach (counts[i]) counts[i] = 0;
    for (int b = 0; b < win_ids.size(); b++) begin
      int w;
      if ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tdata  = {16'($urandom), 16'(win_ids[b]), 16'($urandom)};
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == win_ids.size() - 1);
      w = 0;
      while (!s_axis_tready) begin
        @(negedge clk);
        w++;
        if (w > 300) begin
          check("tready_timeout", 0, 1);
          $fatal(1, "stream stalled");
        end
      end
      tl = cyc + 1;
      win++;
      if (win_ids[b] < NC) counts[win_ids[b]]++;
      else model_dropped++;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (push) begin
      maxv = 0;
      foreach (counts[i]) if ((counts[i] > CMAX ? CMAX : counts[i]) > maxv) maxv = (counts[i] > CMAX ? CMAX : counts[i]);
      cls = -1;
      foreach (counts[i]) if (cls < 0 && (counts[i] > CMAX ? CMAX : counts[i]) == maxv) cls = i;
      e.cls = cls;
      e.cnt = maxv;
      e.win = win;
      e.drop = model_dropped;
      e.tlast_cyc = tl;
      e.hold = hold;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("drain", (exp_q.size() == 0 && !mon_busy), 1);
  endtask

  // Monitor / result consumer.
  initial begin
    bit   prev_valid;
    exp_t e;
    int   hold;
    int   rise;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 0;
      end else begin
        if (result_valid && !prev_valid) begin
          mon_busy = 1;
          rise = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
            hold = 0;
          end else begin
            e = exp_q.pop_front();
            check("result_class", result_class, e.cls);
            check("result_count", result_count, e.cnt);
            check("window_spikes", window_spikes, e.win);
            check("dropped_spikes", dropped_spikes, e.drop);
            check("latency", rise - e.tlast_cyc, NC + 1);
            hold = (e.hold > 0) ? e.hold : $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
              @(negedge clk);
              check("hold_valid", result_valid, 1);
              check("hold_class", result_class, e.cls);
              check("hold_count", result_count, e.cnt);
              check("hold_tready", s_axis_tready, 0);
            end
          end
          result_ready = 1'b1;
          @(negedge clk);
          result_ready = 1'b0;
          check("valid_after_take", result_valid, 0);
          check("window_cleared", window_spikes, 0);
          if (exp_q.size() >= 0 && e.cls >= 0) check("class_retained", result_class, e.cls);
          mon_busy = 0;
        end
        prev_valid = result_valid;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", result_valid, 0);
    check("rst_class", result_class, 0);
    check("rst_count", result_count, 0);
    check("rst_window", window_spikes, 0);
    check("rst_dropped", dropped_spikes, 0);
    reset = 1'b0;
    check("rst_tready", s_axis_tready, 1);
    check("rst_busy", busy, 0);

    win_ids = '{3, 3, 3, 7, 7};
    send_window(1, 0);
    wait_idle();
    win_ids = '{2, 5, 2, 5};
    send_window(1, 0);
    wait_idle();
    win_ids = '{12, 300, 1};
    send_window(1, 0);
    wait_idle();

    win_ids.delete();
    for (int i = 0; i < 20; i++) win_ids.push_back(0);
    send_window(1, 10);
    wait_idle();
    win_ids = '{4};
    send_window(1, 0);
    wait_idle();
    win_ids = '{50000, 10};
    send_window(1, 0);
    wait_idle();

    enable = 1'b0;
    @(negedge clk);
    check("disabled_tready", s_axis_tready, 0);
    check("disabled_busy", busy, 0);
    enable = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 25; w++) begin
      int len;
      len = $urandom_range(1, 30);
      win_ids.delete();
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) win_ids.push_back($urandom_range(NC, 65535));
        else win_ids.push_back($urandom_range(0, NC - 1));
      end
      send_window(1, 0);
    end
    wait_idle();

    win_ids = '{3, 3, 3};
    send_window(0, 0);
    repeat (2) @(negedge clk);
    check("abort_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_dropped = 0;
    check("abort_tready", s_axis_tready, 1);
    check("abort_valid", result_valid, 0);
    check("abort_window", window_spikes, 0);
    check("abort_dropped", dropped_spikes, 0);
    repeat (20) @(negedge clk);
    check("abort_no_result", result_valid, 0);
    win_ids = '{5};
    send_window(1, 0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_spike_count_decoder.md
SNN_SPIKE_COUNT_DECODER -- requirements
Module: snn_spike_count_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48, spike event width (matches layer manager output stream).
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of output neurons counted (2..256).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, per-class counter width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  when low: FSM holds state, s_axis_tready=0.
REQ-007 SHALL have ports s_axis_tdata  input  DATA_WIDTH, s_axis_tvalid  input  1, s_axis_tready  output  1, s_axis_tlast  input  1; spike events from the layer manager output; tlast marks end of inference window.
REQ-008 SHALL have port result_class  output  8  winning neuron index.
REQ-009 SHALL have port result_count  output  COUNT_WIDTH  winner's spike count.
REQ-010 SHALL have ports result_valid  output  1 and result_ready  input  1  result handshake.
REQ-011 SHALL have port window_spikes  output  32  events accepted in current/last window.
REQ-012 SHALL have port dropped_spikes  output  32  cumulative events with out-of-range neuron id.
REQ-013 SHALL have port busy  output  1  high in any state except ACCUM.

Function
REQ-014 SHALL take neuron id from tdata[31:16]; tdata[47:32] (timestamp) and [15:0] ignored.
REQ-015 SHALL implement states ACCUM, ARGMAX, RESULT; reset enters ACCUM.
REQ-016 ACCUM: s_axis_tready = enable; every handshake beat (tvalid&tready), including the tlast beat, SHALL increment counter[id] if id < NUM_CLASSES, else increment dropped_spikes.
REQ-017 Counters SHALL saturate at 2^COUNT_WIDTH-1; window_spikes and dropped_spikes wrap modulo 2^32.
REQ-018 window_spikes SHALL increment on every accepted beat, in-range or not.
REQ-019 Handshake with tlast=1 SHALL move FSM to ARGMAX next cycle with scan index 0, best=0, best_idx=0.
REQ-020 ARGMAX: tready=0; one counter compared per cycle; replace best only if counter[idx] > best (strict), so ties resolve to lowest index.
REQ-021 After comparing index NUM_CLASSES-1, FSM SHALL enter RESULT; result_valid rises exactly NUM_CLASSES+1 cycles after the tlast handshake edge.
REQ-022 RESULT: result_valid=1, result_class/result_count stable until result_ready; tready=0 (backpressure upstream).
REQ-023 On result_valid&result_ready: all class counters and window_spikes SHALL clear on that edge; FSM returns to ACCUM; result_valid low next cycle.
REQ-024 All-zero window SHALL report class 0, count 0.
REQ-025 enable low in ARGMAX/RESULT SHALL freeze scan index and outputs; result_valid remains asserted while frozen in RESULT.
REQ-026 result_class/result_count SHALL retain last value outside RESULT.

Reset
REQ-027 Reset SHALL clear all counters, window_spikes, dropped_spikes, result_class, result_count, result_valid, scan index; state=ACCUM.
REQ-028 Reset asserted mid-ARGMAX or mid-RESULT SHALL abort; no result emitted.
REQ-029 After reset deassertion, s_axis_tready=1 on the first cycle if enable=1.

Structure
REQ-030 Stream field positions (ID_MSB=31, ID_LSB=16, TS_MSB=47, TS_LSB=32) and FSM state encodings SHALL live in shared package snn_pkg.
REQ-031 No sub-module; counters as register array, single sequential comparator.

Verification
REQ-032 Events ids 3,3,3,7,7 (last on 5th), NUM_CLASSES=10 -> result_class=3, result_count=3, result_valid at tlast edge+11 cycles.
REQ-033 Ids 2,5 each twice -> tie -> result_class=2, count=2.
REQ-034 Ids 12 and 300 with tlast on id 1 -> dropped_spikes=2, window_spikes=3, result_class=1, count=1.
REQ-035 COUNT_WIDTH=4, 20 events id 0 -> result_count=15 (saturation); hold result_ready=0 10 cycles -> outputs stable, tready=0; then ready=1 -> counters cleared, next window independent.
REQ-036 Reset asserted 3 cycles into ARGMAX -> result_valid never rises, all counters 0, tready=1 next cycle.
